// File: rtl/avm_uart_responder_pkg.sv
// Shared definitions for the Avalon-MM UART responder.
// Register byte offsets, STATUS bit positions and the frame FSM state type
// used by both serial directions.
package uart_pkg;

  localparam int unsigned RX_BASE     = 0;
  localparam int unsigned TX_BASE     = 4;
  localparam int unsigned STATUS_BASE = 8;

  localparam int unsigned RRDY = 7;
  localparam int unsigned TRDY = 6;
  localparam int unsigned TMT  = 5;
  localparam int unsigned TOE  = 4;
  localparam int unsigned ROE  = 3;
  localparam int unsigned FE   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } frame_state_t;

endpackage

// File: rtl/avm_uart_responder_if.sv
// Avalon-MM slave bus bundle for the UART responder.
// Signals: avs_address (byte address), avs_read, avs_write, avs_writedata,
// avs_readdata, avs_waitrequest. master drives requests, slave responds.
interface avm_uart_responder_if #(
  parameter int unsigned ADDR_W = 5
) ();

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/avm_uart_responder_bit_timer.sv
// Bit-period timer for one UART direction.
// Ports: clk, rst (async, active-high), load (restart the period),
// half (when loading, use DIVISOR/2 instead of DIVISOR), tick (period elapsed).
// A period of N cycles loads N-1 and ticks while the count sits at zero, so
// a state entered with load and left on tick lasts exactly N cycles.
module uart_bit_timer #(
  parameter int unsigned DIVISOR = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIVISOR);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= half ? CW'(DIVISOR / 2 - 1) : CW'(DIVISOR - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/avm_uart_responder.sv
// Avalon-MM UART responder: RXDATA/TXDATA/STATUS register map over an 8N1,
// LSB-first serial link.
// Ports: avm_clk, avm_rst (async, active-high), avs (Avalon slave modport),
// uart_rxd (asynchronous serial in), uart_txd (registered serial out, idle 1).
// Every bus access takes two cycles; readdata is captured in the first and
// side effects happen in the second (ack) cycle.
module avm_uart_responder
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 434,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  avm_uart_responder_if.slave avs,
  input  logic                uart_rxd,
  output logic                uart_txd
);

  logic        ack, req, rd_done, wr_done;
  logic        sel_rx, sel_tx, sel_st;
  logic        wr_tx, wr_st, rd_rx;
  logic [31:0] rd_mux;
  logic        rrdy, trdy, tmt, toe, roe, fe;
  logic [7:0]  rx_byte, tx_hold;
  logic        unused_wdata;

  assign unused_wdata = ^avs.avs_writedata[31:8];

  assign req                 = avs.avs_read | avs.avs_write;
  assign avs.avs_waitrequest = req & ~ack;
  assign rd_done             = ack & avs.avs_read;
  assign wr_done             = ack & avs.avs_write & ~avs.avs_read;

  assign sel_rx = (avs.avs_address == ADDR_W'(RX_BASE));
  assign sel_tx = (avs.avs_address == ADDR_W'(TX_BASE));
  assign sel_st = (avs.avs_address == ADDR_W'(STATUS_BASE));
  assign wr_tx  = wr_done & sel_tx;
  assign wr_st  = wr_done & sel_st;
  assign rd_rx  = rd_done & sel_rx;

  always_comb begin
    rd_mux = '0;
    if (sel_rx) begin
      rd_mux[7:0] = rx_byte;
    end else if (sel_st) begin
      rd_mux[RRDY] = rrdy;
      rd_mux[TRDY] = trdy;
      rd_mux[TMT]  = tmt;
      rd_mux[TOE]  = toe;
      rd_mux[ROE]  = roe;
      rd_mux[FE]   = fe;
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      ack              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      ack <= req & ~ack;
      if (avs.avs_read && !ack) avs.avs_readdata <= rd_mux;
    end
  end

  // ---------------- transmitter ----------------
  frame_state_t tx_state, tx_next;
  logic [7:0]   tx_shift, tx_shift_n;
  logic [2:0]   tx_cnt, tx_cnt_n;
  logic         txd_n, tx_unload, tx_done, tx_load, tx_tick, trdy_eff;

  uart_bit_timer #(.DIVISOR(DIVISOR)) u_tx_timer (
    .clk(avm_clk), .rst(avm_rst), .load(tx_load), .half(1'b0), .tick(tx_tick)
  );

  // txd_n is the line level for the state being entered, so uart_txd stays
  // registered yet changes on the same edge as the state.
  always_comb begin
    tx_next    = tx_state;
    tx_shift_n = tx_shift;
    tx_cnt_n   = tx_cnt;
    txd_n      = uart_txd;
    tx_unload  = 1'b0;
    tx_done    = 1'b0;
    tx_load    = 1'b0;
    unique case (tx_state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (!trdy) begin
          tx_unload  = 1'b1;
          tx_shift_n = tx_hold;
          tx_next    = S_START;
          txd_n      = 1'b0;
          tx_load    = 1'b1;
        end
      end
      S_START: if (tx_tick) begin
        tx_next  = S_DATA;
        txd_n    = tx_shift[0];
        tx_cnt_n = '0;
        tx_load  = 1'b1;
      end
      S_DATA: if (tx_tick) begin
        tx_load = 1'b1;
        if (tx_cnt == 3'd7) begin
          tx_next = S_STOP;
          txd_n   = 1'b1;
        end else begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          txd_n      = tx_shift[1];
          tx_cnt_n   = tx_cnt + 3'd1;
        end
      end
      S_STOP: if (tx_tick) begin
        if (!trdy) begin
          tx_unload  = 1'b1;
          tx_shift_n = tx_hold;
          tx_next    = S_START;
          txd_n      = 1'b0;
          tx_load    = 1'b1;
        end else begin
          tx_next = S_IDLE;
          tx_done = 1'b1;
          txd_n   = 1'b1;
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_state <= S_IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_shift <= tx_shift_n;
      tx_cnt   <= tx_cnt_n;
      uart_txd <= txd_n;
    end
  end

  // ---------------- receiver ----------------
  frame_state_t rx_state, rx_next;
  logic [7:0]   rx_shift, rx_shift_n;
  logic [2:0]   rx_cnt, rx_cnt_n;
  logic         rx_s1, rx_s2, rx_load, rx_half, rx_tick, rx_commit, rx_ferr;

  uart_bit_timer #(.DIVISOR(DIVISOR)) u_rx_timer (
    .clk(avm_clk), .rst(avm_rst), .load(rx_load), .half(rx_half), .tick(rx_tick)
  );

  always_comb begin
    rx_next    = rx_state;
    rx_shift_n = rx_shift;
    rx_cnt_n   = rx_cnt;
    rx_load    = 1'b0;
    rx_half    = 1'b0;
    rx_commit  = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state)
      S_IDLE: if (!rx_s2) begin
        rx_next = S_START;
        rx_load = 1'b1;
        rx_half = 1'b1;
      end
      S_START: if (rx_tick) begin
        if (!rx_s2) begin
          rx_next  = S_DATA;
          rx_load  = 1'b1;
          rx_cnt_n = '0;
        end else begin
          rx_next = S_IDLE;
        end
      end
      S_DATA: if (rx_tick) begin
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        rx_load    = 1'b1;
        if (rx_cnt == 3'd7) rx_next = S_STOP;
        else                rx_cnt_n = rx_cnt + 3'd1;
      end
      S_STOP: if (rx_tick) begin
        rx_commit = rx_s2;
        rx_ferr   = ~rx_s2;
        rx_next   = S_IDLE;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= S_IDLE;
      rx_shift <= '0;
      rx_cnt   <= '0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      rx_shift <= rx_shift_n;
      rx_cnt   <= rx_cnt_n;
    end
  end

  // ---------------- register state ----------------
  // TRDY is judged after a same-cycle unload, so a write racing the
  // transmitter emptying the holding register is accepted.
  assign trdy_eff = trdy | tx_unload;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_hold <= '0;
      trdy    <= 1'b1;
      tmt     <= 1'b1;
      toe     <= 1'b0;
      rx_byte <= '0;
      rrdy    <= 1'b0;
      roe     <= 1'b0;
      fe      <= 1'b0;
    end else begin
      if (wr_tx && trdy_eff) begin
        tx_hold <= avs.avs_writedata[7:0];
        trdy    <= 1'b0;
      end else if (tx_unload) begin
        trdy <= 1'b1;
      end

      if (tx_unload)    tmt <= 1'b0;
      else if (tx_done) tmt <= 1'b1;

      if (wr_tx && !trdy_eff) toe <= 1'b1;
      else if (wr_st)         toe <= 1'b0;

      if (rx_commit) rx_byte <= rx_shift;

      if (rx_commit)  rrdy <= 1'b1;
      else if (rd_rx) rrdy <= 1'b0;

      if (rx_commit && rrdy && !rd_rx) roe <= 1'b1;
      else if (wr_st)                  roe <= 1'b0;

      if (rx_ferr)    fe <= 1'b1;
      else if (wr_st) fe <= 1'b0;
    end
  end

endmodule
